// File: rtl/ram_ptr_unit.sv
// rtl/ram_ptr_unit.sv - bus-mapped RAM with multiple auto-updating pointers and a prefetched read buffer
//
// Register map, as an offset from BASE_ADDR:
//   0 .. PTR_NUM-1  PTRk    pointer k (read/write)
//   PTR_NUM         CTRL    [1:0] mode: 00 hold, 01 post-increment, 10 post-decrement, 11 hold
//                           [2+:SEL_W] selected pointer
//   PTR_NUM+1       DATA    RAM word at PTR[sel]
//   PTR_NUM+2       STATUS  bit0 rd_valid, bit1 wrap (sticky), bit2 underrun (sticky);
//                           writing 1 clears bit1/bit2
//
// Ports:
//   clk           system clock; all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   addr_bus      bus register address
//   data_bus_in   bus write data
//   bus_we        write strobe, one cycle per access
//   bus_re        read strobe, one cycle per access
//   data_bus_out  read data; all-zero when this unit is not being read, so it can be ORed onto the bus
module ram_ptr_unit #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    RAM_ADDR_WIDTH = 8,
  parameter int                    PTR_NUM        = 2,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR      = 8'h20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] addr_bus,
  input  logic [DATA_WIDTH-1:0] data_bus_in,
  input  logic                  bus_we,
  input  logic                  bus_re,
  output logic [DATA_WIDTH-1:0] data_bus_out
);

  localparam int SEL_W = (PTR_NUM > 1) ? $clog2(PTR_NUM) : 1;
  localparam int AW    = RAM_ADDR_WIDTH;

  localparam logic [DATA_WIDTH-1:0] OFF_CTRL   = DATA_WIDTH'(PTR_NUM);
  localparam logic [DATA_WIDTH-1:0] OFF_DATA   = DATA_WIDTH'(PTR_NUM + 1);
  localparam logic [DATA_WIDTH-1:0] OFF_STATUS = DATA_WIDTH'(PTR_NUM + 2);

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  // Out-of-range selectors fall back to pointer 0.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    return ({1'b0, s} < (SEL_W+1)'(PTR_NUM)) ? s : '0;
  endfunction

  logic [DATA_WIDTH-1:0] mem [2**AW];

  logic [AW-1:0]         ptr [PTR_NUM];
  logic [1:0]            mode;
  logic [SEL_W-1:0]      sel_raw;
  logic [DATA_WIDTH-1:0] rdbuf;
  logic                  rd_valid;
  logic                  wrap;
  logic                  underrun;
  state_t                state;

  logic [DATA_WIDTH-1:0] offset;
  logic                  hit_ptr, hit_ctrl, hit_data, hit_status;
  logic [SEL_W-1:0]      ptr_idx;
  logic [SEL_W-1:0]      sel_eff;
  logic [SEL_W-1:0]      sel_new;
  logic                  auto_upd;
  logic [AW-1:0]         cur_ptr;
  logic [AW-1:0]         upd_ptr;
  logic                  upd_wrap;
  logic                  rd_only;
  logic                  ptr_wr, ctrl_wr, data_wr, status_wr;
  logic                  data_rd_ok, data_rd_under;
  logic                  trigger;

  // Address decode
  assign offset     = addr_bus - BASE_ADDR;
  assign hit_ptr    = (offset < OFF_CTRL);
  assign hit_ctrl   = (offset == OFF_CTRL);
  assign hit_data   = (offset == OFF_DATA);
  assign hit_status = (offset == OFF_STATUS);
  assign ptr_idx    = offset[SEL_W-1:0];

  assign sel_eff  = clamp_sel(sel_raw);
  assign sel_new  = clamp_sel(data_bus_in[2 +: SEL_W]);
  assign auto_upd = (mode == 2'b01) || (mode == 2'b10);

  // A simultaneous write and read is treated as a write alone.
  assign rd_only       = bus_re && !bus_we;
  assign ptr_wr        = bus_we && hit_ptr;
  assign ctrl_wr       = bus_we && hit_ctrl;
  assign data_wr       = bus_we && hit_data;
  assign status_wr     = bus_we && hit_status;
  assign data_rd_ok    = rd_only && hit_data && rd_valid;
  assign data_rd_under = rd_only && hit_data && !rd_valid;

  // Post-update value of the selected pointer and whether it wraps around.
  always_comb begin
    cur_ptr  = ptr[sel_eff];
    upd_ptr  = cur_ptr;
    upd_wrap = 1'b0;
    if (mode == 2'b01) begin
      upd_ptr  = cur_ptr + AW'(1);
      upd_wrap = &cur_ptr;
    end else if (mode == 2'b10) begin
      upd_ptr  = cur_ptr - AW'(1);
      upd_wrap = ~|cur_ptr;
    end
  end

  // Anything that can change the word at PTR[sel] invalidates the read buffer.
  assign trigger = (ptr_wr && (ptr_idx == sel_eff))
                || (ctrl_wr && (sel_new != sel_eff))
                || data_wr
                || (data_rd_ok && auto_upd);

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (data_wr) begin
      mem[ptr[sel_eff]] <= data_bus_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PTR_NUM; i++) begin
        ptr[i] <= '0;
      end
      mode     <= 2'b00;
      sel_raw  <= '0;
      rdbuf    <= '0;
      rd_valid <= 1'b0;
      wrap     <= 1'b0;
      underrun <= 1'b0;
      state    <= S_FETCH;
    end else begin
      if (ptr_wr) begin
        ptr[ptr_idx] <= data_bus_in[AW-1:0];
      end
      if (ctrl_wr) begin
        mode    <= data_bus_in[1:0];
        sel_raw <= data_bus_in[2 +: SEL_W];
      end
      if ((data_wr || data_rd_ok) && auto_upd) begin
        ptr[sel_eff] <= upd_ptr;
        if (upd_wrap) begin
          wrap <= 1'b1;
        end
      end
      if (status_wr) begin
        if (data_bus_in[1]) wrap     <= 1'b0;
        if (data_bus_in[2]) underrun <= 1'b0;
      end
      if (data_rd_under) begin
        underrun <= 1'b1;
      end

      // Fetch FSM: the RAM is read during the FETCH cycle using the pointer as it
      // stands after the triggering edge; a fresh trigger restarts the fetch.
      if (trigger) begin
        state    <= S_FETCH;
        rd_valid <= 1'b0;
      end else if (state == S_FETCH) begin
        rdbuf    <= mem[ptr[sel_eff]];
        rd_valid <= 1'b1;
        state    <= S_IDLE;
      end
    end
  end

  // Read mux, combinational from registers.
  always_comb begin
    data_bus_out = '0;
    if (rd_only) begin
      if (hit_ptr) begin
        data_bus_out = DATA_WIDTH'(ptr[ptr_idx]);
      end else if (hit_ctrl) begin
        data_bus_out = DATA_WIDTH'({sel_raw, mode});
      end else if (hit_data) begin
        data_bus_out = rd_valid ? rdbuf : '0;
      end else if (hit_status) begin
        data_bus_out = DATA_WIDTH'({underrun, wrap, rd_valid});
      end
    end
  end

endmodule
